// File: rtl/logic_writeback_multi_pkg.sv
// Shared definitions for the multi-lane writeback stage.
//   wb_state_t    : writeback FSM state encoding (IDLE, RUN)
//   DEF_*         : default configuration (one cell per beat, 640x480 frame)
//   addr_t/data_t : address and word types for the default configuration
//   pop_width()   : width needed to hold a full-frame live-cell count
package logic_writeback_multi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } wb_state_t;

   localparam int DEF_NUM_PE      = 1;
   localparam int DEF_WORD_SIZE   = 32;
   localparam int DEF_FRAME_WORDS = 9600;
   localparam int DEF_ADDR_W      = 15;

   typedef logic [DEF_ADDR_W-1:0]    addr_t;
   typedef logic [DEF_WORD_SIZE-1:0] data_t;

   function automatic int pop_width(input int frame_words, input int word_size);
      return $clog2(frame_words * word_size + 1);
   endfunction

endpackage

// File: rtl/logic_writeback_multi_pe_popcount.sv
// Combinational population count of one PE beat.
//   bits  : NUM_PE next-state cells
//   count : number of set cells, $clog2(NUM_PE+1) bits
module logic_writeback_multi_pe_popcount #(
   parameter int NUM_PE = 1
) (
   input  logic [NUM_PE-1:0]          bits,
   output logic [$clog2(NUM_PE+1)-1:0] count
);

   localparam int CNT_W = $clog2(NUM_PE + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         count = count + CNT_W'(bits[i]);
      end
   end

endmodule

// File: rtl/logic_writeback_multi.sv
// Packs NUM_PE-wide next-state beats into WORD_SIZE-bit words and writes one
// frame to board memory, counting live cells along the way.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   start_in         : begin/restart a frame; buf_sel_in picks the base
//   stall_in         : blocks beat acceptance
//   valid_in         : next_state_in carries a beat (MSB = lane 0)
//   wr_en_out        : one-cycle write strobe with addr_w_out/data_w_out
//   busy_out         : frame in progress
//   done_out         : pulse with the final word's write
//   pop_count_out    : live cells in the last completed frame
module logic_writeback_multi
   import logic_writeback_multi_pkg::*;
#(
   parameter  int NUM_PE      = DEF_NUM_PE,
   parameter  int WORD_SIZE   = DEF_WORD_SIZE,
   parameter  int FRAME_WORDS = DEF_FRAME_WORDS,
   parameter  int ADDR_W      = DEF_ADDR_W,
   localparam int POP_W       = pop_width(FRAME_WORDS, WORD_SIZE)
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic                 buf_sel_in,
   input  logic                 stall_in,
   input  logic                 valid_in,
   input  logic [NUM_PE-1:0]    next_state_in,
   output logic                 wr_en_out,
   output logic [ADDR_W-1:0]    addr_w_out,
   output logic [WORD_SIZE-1:0] data_w_out,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [POP_W-1:0]     pop_count_out
);

   localparam int BEATS  = WORD_SIZE / NUM_PE;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int PC_W   = $clog2(NUM_PE + 1);

   if (WORD_SIZE % NUM_PE != 0) begin : g_bad_pe
      $error("WORD_SIZE must be a multiple of NUM_PE");
   end
   if (64'(2 * FRAME_WORDS) > (64'd1 << ADDR_W)) begin : g_bad_addr
      $error("ADDR_W too small for two frame buffers");
   end

   wb_state_t             state;
   logic [ADDR_W-1:0]     base;
   logic [BEAT_W-1:0]     beat_cnt;
   logic [WIDX_W-1:0]     word_idx;
   logic [WORD_SIZE-1:0]  shreg;
   logic [POP_W-1:0]      run_cnt;
   logic [PC_W-1:0]       beat_pop;

   logic [ADDR_W-1:0]     base_eff;
   logic [BEAT_W-1:0]     beat_eff;
   logic [WIDX_W-1:0]     idx_eff;
   logic [WORD_SIZE-1:0]  shreg_eff;
   logic [POP_W-1:0]      cnt_eff;
   logic [WORD_SIZE-1:0]  word_next;
   logic [POP_W-1:0]      cnt_next;
   logic                  accept;
   logic                  word_done;
   logic                  last_word;

   logic_writeback_multi_pe_popcount #(
      .NUM_PE (NUM_PE)
   ) u_pe_popcount (
      .bits  (next_state_in),
      .count (beat_pop)
   );

   // A start cycle sees the frame state as freshly cleared, so the beat that
   // arrives with start_in becomes the first beat of the new frame and any
   // partial word of an aborted frame is dropped.
   always_comb begin
      base_eff  = start_in ? (buf_sel_in ? ADDR_W'(FRAME_WORDS) : '0) : base;
      beat_eff  = start_in ? '0 : beat_cnt;
      idx_eff   = start_in ? '0 : word_idx;
      shreg_eff = start_in ? '0 : shreg;
      cnt_eff   = start_in ? '0 : run_cnt;
      accept    = (state == RUN || start_in) && valid_in && !stall_in;
      // Earlier beats move up; the newest beat fills the low lanes.
      word_next = (shreg_eff << NUM_PE) | WORD_SIZE'(next_state_in);
      cnt_next  = cnt_eff + POP_W'(beat_pop);
      word_done = accept && (beat_eff == BEAT_W'(BEATS - 1));
      last_word = (idx_eff == WIDX_W'(FRAME_WORDS - 1));
   end

   // Registered control, packing and write outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= IDLE;
         base          <= '0;
         beat_cnt      <= '0;
         word_idx      <= '0;
         shreg         <= '0;
         run_cnt       <= '0;
         wr_en_out     <= 1'b0;
         addr_w_out    <= '0;
         data_w_out    <= '0;
         busy_out      <= 1'b0;
         done_out      <= 1'b0;
         pop_count_out <= '0;
      end else begin
         wr_en_out <= 1'b0;
         done_out  <= 1'b0;

         // busy_out drops one cycle after the done pulse is visible.
         if (start_in) begin
            state    <= RUN;
            base     <= base_eff;
            busy_out <= 1'b1;
         end else if (done_out) begin
            busy_out <= 1'b0;
         end

         if (accept) begin
            run_cnt <= cnt_next;
            if (word_done) begin
               beat_cnt   <= '0;
               shreg      <= '0;
               wr_en_out  <= 1'b1;
               data_w_out <= word_next;
               addr_w_out <= base_eff + ADDR_W'(idx_eff);
               if (last_word) begin
                  done_out      <= 1'b1;
                  pop_count_out <= cnt_next;
                  state         <= IDLE;
                  word_idx      <= '0;
               end else begin
                  word_idx <= idx_eff + WIDX_W'(1);
               end
            end else begin
               beat_cnt <= beat_eff + BEAT_W'(1);
               shreg    <= word_next;
               word_idx <= idx_eff;
            end
         end else if (start_in) begin
            beat_cnt <= '0;
            word_idx <= '0;
            shreg    <= '0;
            run_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_logic_writeback_multi.sv
module tb_logic_writeback_multi;

   logic        clk_in;
   logic        rst_n_in;
   logic        start_in;
   logic        buf_sel_in;
   logic        stall_in;
   logic        valid_in;
   logic [3:0]  next_state_in;
   logic        wr_en_out;
   logic [3:0]  addr_w_out;
   logic [15:0] data_w_out;
   logic        busy_out;
   logic        done_out;
   logic [5:0]  pop_count_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_done   = 0;

   logic [3:0]  q_addr[$];
   logic [15:0] q_data[$];
   int          q_cyc[$];
   bit          q_done[$];

   logic_writeback_multi #(
      .NUM_PE      (4),
      .WORD_SIZE   (16),
      .FRAME_WORDS (3),
      .ADDR_W      (4)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .start_in      (start_in),
      .buf_sel_in    (buf_sel_in),
      .stall_in      (stall_in),
      .valid_in      (valid_in),
      .next_state_in (next_state_in),
      .wr_en_out     (wr_en_out),
      .addr_w_out    (addr_w_out),
      .data_w_out    (data_w_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .pop_count_out (pop_count_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (wr_en_out === 1'b1) begin
         q_addr.push_back(addr_w_out);
         q_data.push_back(data_w_out);
         q_cyc.push_back(cyc);
         q_done.push_back(done_out === 1'b1);
      end
      if (done_out === 1'b1) n_done <= n_done + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // One beat offered for one clock; acc returns the cycle stamp after the edge.
   task automatic beat(input logic [3:0] d, input logic st, input logic sel, output int acc);
      start_in      = st;
      buf_sel_in    = sel;
      valid_in      = 1'b1;
      next_state_in = d;
      tick();
      acc           = cyc;
      start_in      = 1'b0;
      valid_in      = 1'b0;
   endtask

   task automatic run_frame(input logic sel, input logic [3:0] ev, input logic [3:0] od,
                            output int c0, output int c1, output int c2);
      int acc;
      c0 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 12; i++) begin
         beat((i % 2 == 0) ? ev : od, i == 0, sel, acc);
         if (i == 0)  check("busy_after_start", 32'(busy_out), 32'd1);
         if (i == 3)  c0 = acc;
         if (i == 7)  c1 = acc;
         if (i == 11) c2 = acc;
      end
      check("done_with_last", 32'(done_out), 32'd1);
      check("busy_during_done", 32'(busy_out), 32'd1);
      tick();
      check("busy_after_done", 32'(busy_out), 32'd0);
      check("done_one_cycle", 32'(done_out), 32'd0);
      tick();
   endtask

   task automatic check_frame(input string nm, input int qm, input int dm, input logic [3:0] base,
                              input logic [15:0] d, input int c0, input int c1, input int c2,
                              input logic [5:0] pop);
      int exp_c[3];
      exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2;
      check($sformatf("%s_nwrites", nm), 32'(q_addr.size() - qm), 32'd3);
      check($sformatf("%s_ndone", nm), 32'(n_done - dm), 32'd1);
      for (int k = 0; k < 3; k++) begin
         if (qm + k < q_addr.size()) begin
            check($sformatf("%s_addr%0d", nm, k), 32'(q_addr[qm+k]), 32'(base + 4'(k)));
            check($sformatf("%s_data%0d", nm, k), 32'(q_data[qm+k]), 32'(d));
            check($sformatf("%s_cyc%0d", nm, k), 32'(q_cyc[qm+k]), 32'(exp_c[k]));
            check($sformatf("%s_done%0d", nm, k), 32'(q_done[qm+k]), 32'(k == 2));
         end
      end
      check($sformatf("%s_pop", nm), 32'(pop_count_out), 32'(pop));
   endtask

   initial begin
      int qm, dm, a0, a1, a2, a3, c0, c1, c2, acc;
      start_in = 0; buf_sel_in = 0; stall_in = 0; valid_in = 0; next_state_in = 0;
      rst_n_in = 1'b1;
      #2 rst_n_in = 1'b0;

      // Reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         start_in = i[0]; valid_in = 1'b1; next_state_in = 4'hF;
         tick();
      end
      start_in = 0; valid_in = 0;
      check("rst_wr_en", 32'(wr_en_out), 32'd0);
      check("rst_addr", 32'(addr_w_out), 32'd0);
      check("rst_data", 32'(data_w_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_done", 32'(done_out), 32'd0);
      check("rst_pop", 32'(pop_count_out), 32'd0);
      check("rst_nwrites", 32'(q_addr.size()), 32'd0);
      rst_n_in = 1'b1;
      tick();

      // Buffer 0, alternating F/0
      qm = q_addr.size(); dm = n_done;
      run_frame(1'b0, 4'hF, 4'h0, c0, c1, c2);
      check_frame("buf0", qm, dm, 4'd0, 16'hF0F0, c0, c1, c2, 6'd24);

      // Buffer 1, same stimulus
      qm = q_addr.size(); dm = n_done;
      run_frame(1'b1, 4'hF, 4'h0, c0, c1, c2);
      check_frame("buf1", qm, dm, 4'd3, 16'hF0F0, c0, c1, c2, 6'd24);

      // Two-cycle stall after beat 2 of word 0, valid held
      qm = q_addr.size(); dm = n_done;
      beat(4'hF, 1'b1, 1'b0, a0);
      beat(4'h0, 1'b0, 1'b0, a1);
      stall_in = 1'b1; valid_in = 1'b1; next_state_in = 4'hF;
      tick();
      tick();
      stall_in = 1'b0;
      beat(4'hF, 1'b0, 1'b0, a2);
      beat(4'h0, 1'b0, 1'b0, a3);
      for (int i = 4; i < 12; i++) begin
         beat((i % 2 == 0) ? 4'hF : 4'h0, 1'b0, 1'b0, acc);
         if (i == 7)  c1 = acc;
         if (i == 11) c2 = acc;
      end
      tick();
      tick();
      check_frame("stall", qm, dm, 4'd0, 16'hF0F0, a0 + 5, c1, c2, 6'd24);

      // Abort after 5 beats, restart with 12 beats of 4'h1
      dm = n_done;
      for (int i = 0; i < 5; i++) beat((i % 2 == 0) ? 4'hF : 4'h0, i == 0, 1'b0, acc);
      check("abort_no_done", 32'(n_done - dm), 32'd0);
      qm = q_addr.size();
      run_frame(1'b0, 4'h1, 4'h1, c0, c1, c2);
      check_frame("restart", qm, dm, 4'd0, 16'h1111, c0, c1, c2, 6'd12);

      // Reset mid-frame, then beats without start
      for (int i = 0; i < 6; i++) beat((i % 2 == 0) ? 4'hF : 4'h0, i == 0, 1'b0, acc);
      rst_n_in = 1'b0;
      #1;
      check("midrst_wr_en", 32'(wr_en_out), 32'd0);
      check("midrst_addr", 32'(addr_w_out), 32'd0);
      check("midrst_data", 32'(data_w_out), 32'd0);
      check("midrst_busy", 32'(busy_out), 32'd0);
      check("midrst_pop", 32'(pop_count_out), 32'd0);
      tick();
      rst_n_in = 1'b1;
      tick();
      qm = q_addr.size(); dm = n_done;
      for (int i = 0; i < 8; i++) beat(4'hF, 1'b0, 1'b0, acc);
      tick();
      tick();
      check("norestart_nwrites", 32'(q_addr.size() - qm), 32'd0);
      check("norestart_ndone", 32'(n_done - dm), 32'd0);
      check("norestart_busy", 32'(busy_out), 32'd0);
      check("norestart_data", 32'(data_w_out), 32'd0);
      check("norestart_pop", 32'(pop_count_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
